// File: rtl/keccak_padder.sv
// Keccak/SHA-3 multi-rate padder: packs W-bit words into RATE-bit blocks, applies the
// domain suffix and final 0x80 bit, and hands each block to the permutation on f_ack.
module keccak_padder #(
  parameter int unsigned W    = 32,
  parameter int unsigned RATE = 576,
  parameter logic [7:0]  DSEP = 8'h06,
  localparam int unsigned BN  = $clog2(W / 8)
) (
  input  logic            clk_i,
  input  logic            reset_n,
  input  logic [W-1:0]    in_i,
  input  logic            in_ready_i,
  input  logic            is_last_i,
  input  logic [BN-1:0]   byte_num_i,
  output logic            in_ack_o,
  output logic [RATE-1:0] out_o,
  output logic            out_ready_o,
  output logic            out_last_o,
  input  logic            f_ack_i
);

  localparam int unsigned N  = RATE / W;
  localparam int unsigned NB = W / 8;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [CW-1:0] CntFull = CW'(N);
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  typedef enum logic [1:0] {
    StAbsorb,
    StPad,
    StFullLast
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RATE-1:0] out_q, out_d;
  logic [RATE-1:0] shifted;
  logic [W-1:0]    last_word;
  logic [W-1:0]    v;
  logic            shift;
  logic            in_ack;
  logic            full;
  logic            at_last;

  assign full    = (cnt_q == CntFull);
  assign at_last = (cnt_q == CntLast);

  // Bytes before byte_num keep the data, byte_num carries the suffix, the rest are zero.
  always_comb begin
    last_word = in_i;
    for (int unsigned i = 0; i < NB; i++) begin
      if (BN'(i) == byte_num_i) begin
        last_word[W-1-8*i -: 8] = DSEP;
      end else if (BN'(i) > byte_num_i) begin
        last_word[W-1-8*i -: 8] = 8'h00;
      end
    end
  end

  if (RATE > W) begin : g_shift
    assign shifted = {out_q[RATE-W-1:0], v};
  end else begin : g_noshift
    assign shifted = v;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    v       = '0;
    shift   = 1'b0;
    in_ack  = 1'b0;

    unique case (state_q)
      StAbsorb: begin
        if (full) begin
          if (f_ack_i) begin
            cnt_d = '0;
          end
        end else if (in_ready_i) begin
          in_ack = 1'b1;
          shift  = 1'b1;
          if (is_last_i) begin
            v = last_word;
            if (at_last) begin
              v[7]    = 1'b1;
              state_d = StFullLast;
            end else begin
              state_d = StPad;
            end
          end else begin
            v = in_i;
          end
        end
      end
      StPad: begin
        shift = 1'b1;
        if (at_last) begin
          v[7]    = 1'b1;
          state_d = StFullLast;
        end
      end
      StFullLast: begin
        if (f_ack_i) begin
          cnt_d   = '0;
          state_d = StAbsorb;
        end
      end
      default: state_d = StAbsorb;
    endcase

    if (shift) begin
      out_d = shifted;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StAbsorb;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Gated so an in_ready held through reset is never acknowledged.
  assign in_ack_o    = in_ack & reset_n;
  assign out_o       = out_q;
  assign out_ready_o = full;
  assign out_last_o  = (state_q == StFullLast);

endmodule

// File: tb/tb_keccak_padder.sv
// Randomized scoreboard bench for keccak_padder: a SHA-3 style byte-level padding model
// predicts every block; per-instance sinks compare blocks and exercise f_ack backpressure.
module tb_keccak_padder;

  localparam int MaxR = 1088;

  typedef struct {
    logic [MaxR-1:0] blk;
    bit              last;
  } exp_t;

  logic            clk;
  logic [63:0]     in_s       [2];
  logic            in_ready_s [2];
  logic            is_last_s  [2];
  logic [2:0]      bn_s       [2];
  logic            rst_s      [2];
  logic            f_ack_s    [2];
  logic            in_ack_s   [2];
  logic            out_ready_s[2];
  logic            out_last_s [2];
  logic [MaxR-1:0] out_s      [2];
  logic [575:0]    out_a;
  logic [1087:0]   out_b;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp;
  int   n_err;

  keccak_padder #(.W(32), .RATE(576), .DSEP(8'h06)) u_dut_a (
    .clk_i      (clk),
    .reset_n    (rst_s[0]),
    .in_i       (in_s[0][31:0]),
    .in_ready_i (in_ready_s[0]),
    .is_last_i  (is_last_s[0]),
    .byte_num_i (bn_s[0][1:0]),
    .in_ack_o   (in_ack_s[0]),
    .out_o      (out_a),
    .out_ready_o(out_ready_s[0]),
    .out_last_o (out_last_s[0]),
    .f_ack_i    (f_ack_s[0])
  );

  keccak_padder #(.W(64), .RATE(1088), .DSEP(8'h1F)) u_dut_b (
    .clk_i      (clk),
    .reset_n    (rst_s[1]),
    .in_i       (in_s[1]),
    .in_ready_i (in_ready_s[1]),
    .is_last_i  (is_last_s[1]),
    .byte_num_i (bn_s[1]),
    .in_ack_o   (in_ack_s[1]),
    .out_o      (out_b),
    .out_ready_o(out_ready_s[1]),
    .out_last_o (out_last_s[1]),
    .f_ack_i    (f_ack_s[1])
  );

  assign out_s[0] = MaxR'(out_a);
  assign out_s[1] = out_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int w_of(input int d);
    return (d == 0) ? 32 : 64;
  endfunction

  function automatic int rate_of(input int d);
    return (d == 0) ? 576 : 1088;
  endfunction

  function automatic logic [7:0] dsep_of(input int d);
    return (d == 0) ? 8'h06 : 8'h1F;
  endfunction

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void chk_blk(input string name, input logic [MaxR-1:0] got,
                                  input logic [MaxR-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      for (int i = 0; i < MaxR / 64; i++) begin
        if (got[64*i +: 64] !== exp[64*i +: 64]) begin
          $display("FAIL %s: lane %0d got %h expected %h (t=%0t)", name, i, got[64*i +: 64],
                   exp[64*i +: 64], $time);
          break;
        end
      end
    end
  endfunction

  // Reference: message bytes, suffix byte, zero fill to the rate, top bit of the final byte.
  task automatic push_expected(input int d, input logic [7:0] msg[$]);
    logic [7:0] pad[$];
    exp_t       e;
    int         r;
    int         nblk;
    r   = rate_of(d) / 8;
    pad = msg;
    pad.push_back(dsep_of(d));
    while ((pad.size() % r) != 0) pad.push_back(8'h00);
    pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
    nblk = pad.size() / r;
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int j = 0; j < r; j++) e.blk = {e.blk[MaxR-9:0], pad[b*r+j]};
      e.last = (b == nblk - 1);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic send_word(input int d, input logic [63:0] word, input bit last,
                           input logic [2:0] bn);
    bit ok;
    int t;
    in_s[d]       = word;
    is_last_s[d]  = last;
    bn_s[d]       = bn;
    in_ready_s[d] = 1'b1;
    ok = 1'b0;
    t  = 0;
    while (t < 3000) begin
      @(negedge clk);
      if (in_ack_s[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    chk("in_ack_wait", 64'(ok), 64'd1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    in_ready_s[d] = 1'b0;
    // A stray is_last without in_ready must be ignored.
    is_last_s[d]  = 1'($urandom_range(0, 1));
  endtask

  task automatic latency_check(input int d, input int p);
    int k;
    int n;
    n = rate_of(d) / w_of(d);
    k = 0;
    while (out_ready_s[d] !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("pad_latency", 64'(k), 64'(n - 1 - p));
  endtask

  task automatic send_msg(input int d, input int len, input bit do_lat);
    logic [7:0]  msg[$];
    logic [63:0] word;
    int          w;
    int          nbytes;
    int          nw;
    int          n;
    int          idx;
    bit          last;
    w      = w_of(d);
    nbytes = w / 8;
    n      = rate_of(d) / w;
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
    push_expected(d, msg);
    nw = len / nbytes + 1;
    for (int k = 0; k < nw; k++) begin
      word = {$urandom, $urandom};
      for (int i = 0; i < nbytes; i++) begin
        idx = k * nbytes + i;
        if (idx < len) word[w-1-8*i -: 8] = msg[idx];
      end
      last = (k == nw - 1);
      send_word(d, word, last,
                last ? 3'(len % nbytes) : 3'($urandom_range(0, nbytes - 1)));
      if (!last && $urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    if (do_lat) latency_check(d, (nw - 1) % n);
  endtask

  task automatic sink(input int d);
    exp_t            e;
    logic [MaxR-1:0] snap;
    int              hold;
    int              qs;
    f_ack_s[d] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_s[d] !== 1'b1 || out_ready_s[d] !== 1'b1) begin
        // Acks while no block is ready must be ignored.
        f_ack_s[d] = ($urandom_range(0, 3) == 0);
        continue;
      end
      f_ack_s[d] = 1'b0;
      qs = (d == 0) ? q0.size() : q1.size();
      chk("block_pending", 64'(qs > 0), 64'd1);
      if (qs > 0) begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk_blk("block", out_s[d], e.blk);
        chk("out_last", 64'(out_last_s[d]), 64'(e.last));
      end
      snap = out_s[d];
      hold = $urandom_range(0, 6);
      repeat (hold) begin
        @(negedge clk);
        chk_blk("out_stable", out_s[d], snap);
        chk("hold_out_ready", 64'(out_ready_s[d]), 64'd1);
        chk("hold_in_ack", 64'(in_ack_s[d]), 64'd0);
      end
      f_ack_s[d] = 1'b1;
      #1;
      chk("ack_cycle_in_ack", 64'(in_ack_s[d]), 64'd0);
      @(negedge clk);
      f_ack_s[d] = 1'b0;
    end
  endtask

  task automatic seq_a();
    logic [7:0] empty[$];
    int         lens[7];
    lens = '{71, 82, 72, 3, 144, 4, 0};
    rst_s[0]      = 1'b0;
    in_s[0]       = {$urandom, $urandom};
    in_ready_s[0] = 1'b1;
    is_last_s[0]  = 1'b1;
    bn_s[0]       = 3'd0;
    push_expected(0, empty);
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ack", 64'(in_ack_s[0]), 64'd0);
      chk("rst_out_ready", 64'(out_ready_s[0]), 64'd0);
      chk("rst_out_last", 64'(out_last_s[0]), 64'd0);
      chk_blk("rst_out", out_s[0], '0);
    end
    rst_s[0] = 1'b1;
    #1;
    chk("first_in_ack", 64'(in_ack_s[0]), 64'd1);
    @(posedge clk);
    #1;
    in_ready_s[0] = 1'b0;
    is_last_s[0]  = 1'b0;
    latency_check(0, 0);
    foreach (lens[i]) send_msg(0, lens[i], 1'b1);
    repeat (8) send_msg(0, $urandom_range(0, 220), 1'b1);
  endtask

  task automatic seq_b();
    int lens[4];
    lens = '{135, 136, 0, 7};
    rst_s[1]      = 1'b0;
    in_s[1]       = '0;
    in_ready_s[1] = 1'b0;
    is_last_s[1]  = 1'b0;
    bn_s[1]       = 3'd0;
    repeat (2) @(negedge clk);
    rst_s[1] = 1'b1;
    @(posedge clk);
    #1;
    foreach (lens[i]) send_msg(1, lens[i], 1'b1);
    // Reset in the middle of padding a short message.
    send_msg(1, 10, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    in_ready_s[1] = 1'b1;
    rst_s[1]      = 1'b0;
    #1;
    chk_blk("midpad_rst_out", out_s[1], '0);
    chk("midpad_rst_out_ready", 64'(out_ready_s[1]), 64'd0);
    chk("midpad_rst_out_last", 64'(out_last_s[1]), 64'd0);
    chk("midpad_rst_in_ack", 64'(in_ack_s[1]), 64'd0);
    q1.delete();
    @(negedge clk);
    in_ready_s[1] = 1'b0;
    rst_s[1]      = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) send_msg(1, $urandom_range(0, 300), 1'b1);
  endtask

  initial sink(0);
  initial sink(1);

  initial begin
    int t;
    n_cmp = 0;
    n_err = 0;
    fork
      seq_a();
      seq_b();
    join
    t = 0;
    while ((q0.size() + q1.size()) != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
